// File: rtl/text_buffer_pkg.sv
// Shared constants and types for the character-cell text buffer.
package text_buffer_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 16;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCROLL
  } state_t;

  // Everything from space upward is stored; lower codes are control.
  function automatic logic is_printable(input logic [7:0] c);
    return c >= CH_SPACE;
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port cell RAM: one write port, one registered read-first read port.
module text_ram #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Non-blocking read of mem sees the pre-write contents on a same-cell collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Scrolling character screen: byte stream in, per-pixel cell lookup out.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int         COLUMNS           = 80,
  parameter int         ROWS              = 30,
  parameter logic [7:0] DEFAULT_ATTRIBUTE = 8'h0F
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic [7:0] in_attribute,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [7:0] codepoint,
  output logic [7:0] attribute,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int              CELLS     = COLUMNS * ROWS;
  localparam int              AW        = $clog2(CELLS);
  localparam logic [AW-1:0]   LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0]   ROW_CELLS = AW'(COLUMNS);
  localparam logic [AW-1:0]   ROW_OFS   = AW'(COLUMNS - 1);
  localparam logic [6:0]      COL_LAST  = 7'(COLUMNS - 1);
  localparam logic [4:0]      ROW_LAST  = 5'(ROWS - 1);
  localparam logic [9:0]      X_END     = 10'(COLUMNS * CELL_W);
  localparam logic [9:0]      Y_END     = 10'(ROWS * CELL_H);
  localparam logic [15:0]     BLANK     = {CH_SPACE, DEFAULT_ATTRIBUTE};

  state_t        state;
  logic [4:0]    top_row;
  logic [AW-1:0] clr_addr, clr_last;

  // ---------------- read path ----------------
  logic          in_view, view_q;
  logic [6:0]    rd_sum, rd_row;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          unused_pix;

  assign unused_pix = ^{cx[2:0], cy[3:0]};
  assign in_view    = (cx < X_END) && (cy < Y_END);
  assign rd_sum     = 7'(cy[9:4]) + 7'(top_row);
  assign rd_row     = (rd_sum >= 7'(ROWS)) ? rd_sum - 7'(ROWS) : rd_sum;
  assign rd_addr    = in_view ? AW'(rd_row) * ROW_CELLS + AW'(cx[9:3]) : '0;

  // Off-screen flag travels alongside the RAM read so both land together.
  always_ff @(posedge clk_pixel) begin
    if (reset) view_q <= 1'b0;
    else       view_q <= in_view;
  end

  assign codepoint = view_q ? rd_data[15:8] : CH_SPACE;
  assign attribute = view_q ? rd_data[7:0]  : DEFAULT_ATTRIBUTE;

  // ---------------- write path ----------------
  logic          accept, printable, clearing, next_line;
  logic [5:0]    wr_sum;
  logic [4:0]    wr_row, top_next;
  logic [AW-1:0] cursor_addr, scroll_base;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;

  assign accept      = in_valid && in_ready;
  assign printable   = is_printable(in_char);
  assign clearing    = (state != IDLE);
  assign next_line   = accept && ((printable && cursor_col == COL_LAST) || in_char == CH_LF);
  assign wr_sum      = 6'(cursor_row) + 6'(top_row);
  assign wr_row      = (wr_sum >= 6'(ROWS)) ? 5'(wr_sum - 6'(ROWS)) : wr_sum[4:0];
  assign cursor_addr = AW'(wr_row) * ROW_CELLS + AW'(cursor_col);
  // The old top row becomes the new bottom row once top_row advances.
  assign scroll_base = AW'(top_row) * ROW_CELLS;
  assign top_next    = (top_row == ROW_LAST) ? '0 : top_row + 5'd1;

  assign we    = clearing || (accept && printable);
  assign waddr = clearing ? clr_addr : cursor_addr;
  assign wdata = clearing ? BLANK : {in_char, in_attribute};

  text_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .DW    (16)
  ) u_ram (
    .clk   (clk_pixel),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state      <= CLEAR;
      in_ready   <= 1'b0;
      clr_addr   <= '0;
      clr_last   <= LAST_CELL;
      top_row    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      case (state)
        CLEAR, SCROLL: begin
          if (clr_addr == clr_last) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            if (state == CLEAR) begin
              top_row    <= '0;
              cursor_col <= '0;
              cursor_row <= '0;
            end
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (next_line) begin
              cursor_col <= '0;
              if (cursor_row != ROW_LAST) begin
                cursor_row <= cursor_row + 5'd1;
              end else begin
                top_row  <= top_next;
                state    <= SCROLL;
                in_ready <= 1'b0;
                clr_addr <= scroll_base;
                clr_last <= scroll_base + ROW_OFS;
              end
            end else if (printable) begin
              cursor_col <= cursor_col + 7'd1;
            end else begin
              case (in_char)
                CH_CR: cursor_col <= '0;
                CH_BS: if (cursor_col != '0) cursor_col <= cursor_col - 7'd1;
                CH_FF: begin
                  state    <= CLEAR;
                  in_ready <= 1'b0;
                  clr_addr <= '0;
                  clr_last <= LAST_CELL;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          state    <= CLEAR;
          in_ready <= 1'b0;
          clr_addr <= '0;
          clr_last <= LAST_CELL;
        end
      endcase
    end
  end

endmodule
